// File: rtl/if_pkg.sv
// Shared definitions for the fetch/decode buffer: default sizes, decode field
// positions and the buffered entry layout.
package if_pkg;

    localparam int unsigned AW_DEFAULT    = 8;
    localparam int unsigned DEPTH_DEFAULT = 2;
    localparam int unsigned INSTR_W       = 32;

    localparam int unsigned OPC_LSB = 0;
    localparam int unsigned OPC_W   = 7;
    localparam int unsigned RD_LSB  = 7;
    localparam int unsigned RD_W    = 5;
    localparam int unsigned RS1_LSB = 15;
    localparam int unsigned RS1_W   = 5;
    localparam int unsigned RS2_LSB = 20;
    localparam int unsigned RS2_W   = 5;
    localparam int unsigned IMM_LSB = 20;
    localparam int unsigned IMM_W   = 12;

    typedef struct packed {
        logic [AW_DEFAULT-1:0] pc;
        logic [INSTR_W-1:0]    instr;
    } entry_t;

endpackage

// File: rtl/field_extract.sv
// Pure combinational slicing of an instruction word into its decode fields.
module field_extract
    import if_pkg::*;
(
    input  logic [INSTR_W-1:0] instr,
    output logic [OPC_W-1:0]   opcode,
    output logic [RD_W-1:0]    rd,
    output logic [RS1_W-1:0]   rs1,
    output logic [RS2_W-1:0]   rs2,
    output logic [IMM_W-1:0]   imm
);

    // funct3 is not exported by this stage
    logic w_unused_funct3;

    assign opcode          = instr[OPC_LSB +: OPC_W];
    assign rd              = instr[RD_LSB  +: RD_W];
    assign rs1             = instr[RS1_LSB +: RS1_W];
    assign rs2             = instr[RS2_LSB +: RS2_W];
    assign imm             = instr[IMM_LSB +: IMM_W];
    assign w_unused_funct3 = ^instr[14:12];

endmodule

// File: rtl/if_id_buffer.sv
// Small FIFO between fetch and decode with flush; head entry is decoded into
// fields and all outputs are zero while the buffer is empty.
module if_id_buffer
    import if_pkg::*;
#(
    parameter int unsigned DEPTH = DEPTH_DEFAULT,
    parameter int unsigned AW    = AW_DEFAULT
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [AW-1:0]            pc_in,
    input  logic [INSTR_W-1:0]       instr_in,
    input  logic                     flush,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [AW-1:0]            pc_out,
    output logic [INSTR_W-1:0]       instr_out,
    output logic [OPC_W-1:0]         opcode,
    output logic [RD_W-1:0]          rd,
    output logic [RS1_W-1:0]         rs1,
    output logic [RS2_W-1:0]         rs2,
    output logic [IMM_W-1:0]         imm,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;

    logic [PW-1:0] r_head;
    logic [PW-1:0] r_tail;
    logic [CW-1:0] r_count;
    entry_t        r_mem [DEPTH];

    logic   w_push;
    logic   w_pop;
    entry_t w_head;

    // Handshakes depend only on registered occupancy; flush cancels both
    assign in_ready  = (r_count < CW'(DEPTH));
    assign out_valid = (r_count != '0);
    assign w_push    = in_valid && in_ready && !flush;
    assign w_pop     = out_valid && out_ready && !flush;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else if (flush) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) r_tail <= r_tail + PW'(1);
            if (w_pop)  r_head <= r_head + PW'(1);
            r_count <= r_count + CW'(w_push) - CW'(w_pop);
        end
    end

    // Entry storage is not reset; the head is masked by out_valid
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_tail] <= '{pc: AW_DEFAULT'(pc_in), instr: instr_in};
        end
    end

    assign w_head    = r_mem[r_head];
    assign pc_out    = out_valid ? AW'(w_head.pc) : '0;
    assign instr_out = out_valid ? w_head.instr   : '0;
    assign count     = r_count;

    field_extract u_field_extract (
        .instr  (instr_out),
        .opcode (opcode),
        .rd     (rd),
        .rs1    (rs1),
        .rs2    (rs2),
        .imm    (imm)
    );

endmodule
